// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, valid/ready on both sides.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the `sub` input).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] b_load;
  logic             cy_load;
  logic             fa_s, fa_c;

  // Subtraction is A + ~B + 1, so only the latched operand and carry seed differ.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load  = sub ? ~b : b;
    cy_load = sub ? 1'b1 : c_in;
`else
    b_load  = b;
    cy_load = c_in;
`endif
  end

  assign fa_s = a_q[0] ^ b_q[0] ^ cy_q;
  assign fa_c = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    carry_d = carry_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_load;
          cy_d    = cy_load;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Partial sum lives in acc_q; sum_q only updates once all bits are done.
        if (cnt_q == LastCnt) begin
          sum_d   = acc_q;
          carry_d = cy_q;
          state_d = StDone;
        end else begin
          cy_d  = fa_c;
          a_d   = a_q >> 1;
          b_d   = b_q >> 1;
          acc_d = {fa_s, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes expected results, monitor pops on handshake.
module tb_serial_adder;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [W:0] exp_q[$];
  int         acc_q[$];
  logic       mon_en = 1'b0;
  logic       bp_hold = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [W:0] prev_res = '0;
  logic [W:0] last_res = '0;
  logic [W:0] exp_v;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic modulo 2^(W+1).
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic s);
    int unsigned xa, ya, r;
    xa = x;
    ya = y;
    if (s) r = xa + ((1 << W) - 1 - ya) + 1;
    else   r = xa + ya + (ci ? 1 : 0);
    return r[W:0];
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic ts);
    int n = 0;
    logic eff_sub = 1'b0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      return;
    end
    a = ta;
    b = tb;
    c_in = tc;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
    eff_sub = ts;
`endif
    in_valid = 1'b1;
    exp_q.push_back(model(ta, tb, tc, eff_sub));
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    c_in = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        check("in_ready_low_in_done", in_ready, 0);
        if (!prev_valid) begin
          if (acc_q.size() == 0) begin
            failures++;
            $display("FAIL spurious_out_valid actual=1 required=0");
          end else begin
            check("latency", cyc - acc_q.pop_front(), W + 1);
          end
        end else if (!prev_ready) begin
          check("hold_stable", {carry, sum}, prev_res);
        end else begin
          failures++;
          $display("FAIL out_valid_not_dropped actual=1 required=0");
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result actual=%0h required=none", {carry, sum});
          end else begin
            exp_v = exp_q.pop_front();
            check("result", {carry, sum}, exp_v);
            last_res = exp_v;
          end
        end
      end else begin
        check("idle_run_hold", {carry, sum}, last_res);
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_res   = {carry, sum};
    end
  end

  initial begin
    int n;
    logic rs;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", {carry, sum}, 0);
    rst_n = 1'b1;
    last_res = '0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    do_op(8'h0F, 8'h01, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    do_op(8'h00, 8'h00, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b0, 1'b1);
    do_op(8'h07, 8'h05, 1'b1, 1'b1);
`endif
    for (int i = 0; i < 150; i++) begin
      rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`endif
      do_op(W'($urandom), W'($urandom), 1'($urandom), rs);
    end
    drain();

    // Backpressure: DONE must hold, and in_valid must be ignored.
    bp_hold = 1'b1;
    @(posedge clk); #1;
    do_op(8'hA5, 8'h5A, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reached_done", out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
      check("bp_valid_held", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    bp_hold = 1'b0;
    drain();

    // Asynchronous reset in the middle of RUN discards the operation.
    mon_en = 1'b0;
    do_op(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_result", {carry, sum}, 0);
    exp_q.delete();
    acc_q.delete();
    last_res = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    mon_en = 1'b1;
    do_op(8'h12, 8'h34, 1'b0, 1'b0);
    drain();
    @(posedge clk); #1;
    check("post_reset_sum", {carry, sum}, 9'h046);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
